mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port
// (read-only) and a load/store port. Each transaction runs IDLE -> ACCESS
// (MEM_LAT cycles) -> DONE -> IDLE. All outputs are registered.
//
// Parameters:
//   MEM_LAT    memory access cycles per transaction (1..15)
// Optional feature macro:
//   MEM_ARB_RR_EN  defined: simultaneous requests alternate (round-robin)
//                  undefined: simultaneous requests go to the data port
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   i_req/i_addr                 fetch request and address
//   i_gnt/i_done/i_rdata         fetch grant, done pulse, fetched word
//   d_req/d_we/d_addr/d_wdata    load/store request, op, address, data
//   d_gnt/d_done/d_rdata         data grant, done pulse, loaded word
//   mem_rw/mem_addr/mem_wdata    memory command (00 idle/01 rd/10 wr)
//   mem_rdata                    memory read data (valid last ACCESS cycle)
//   busy                         high whenever not IDLE
module mem_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_done,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic [1:0]  mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [1:0] RW_IDLE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;
   localparam logic [3:0] LAT_M1   = 4'(MEM_LAT - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [1:0]  rw_n;
   logic [31:0] addr_n, wdata_n, ird_n, drd_n;
   logic        ig_n, dg_n, idone_n, ddone_n, busy_n;
   logic        d_win;

`ifdef MEM_ARB_RR_EN
   logic last_d, last_d_n;
   // On a tie the data port wins only if the fetch port was served last.
   assign d_win = d_req & (~i_req | ~last_d);
`else
   assign d_win = d_req;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rw_n    = mem_rw;
      addr_n  = mem_addr;
      wdata_n = mem_wdata;
      ig_n    = i_gnt;
      dg_n    = d_gnt;
      idone_n = 1'b0;
      ddone_n = 1'b0;
      ird_n   = i_rdata;
      drd_n   = d_rdata;
      busy_n  = busy;
`ifdef MEM_ARB_RR_EN
      last_d_n = last_d;
`endif
      case (state)
         IDLE: begin
            if (i_req | d_req) begin
               state_n = ACCESS;
               cnt_n   = LAT_M1;
               busy_n  = 1'b1;
`ifdef MEM_ARB_RR_EN
               last_d_n = d_win;
`endif
               if (d_win) begin
                  dg_n    = 1'b1;
                  ig_n    = 1'b0;
                  rw_n    = d_we ? RW_WRITE : RW_READ;
                  addr_n  = d_addr;
                  wdata_n = d_we ? d_wdata : '0;
               end else begin
                  ig_n    = 1'b1;
                  dg_n    = 1'b0;
                  rw_n    = RW_READ;
                  addr_n  = i_addr;
                  wdata_n = '0;
               end
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               // Last access cycle: mem_rdata is valid now.
               state_n = DONE;
               rw_n    = RW_IDLE;
               addr_n  = '0;
               wdata_n = '0;
               if (d_gnt) begin
                  ddone_n = 1'b1;
                  if (mem_rw == RW_READ) drd_n = mem_rdata;
               end else begin
                  idone_n = 1'b1;
                  ird_n   = mem_rdata;
               end
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         DONE: begin
            state_n = IDLE;
            cnt_n   = '0;
            ig_n    = 1'b0;
            dg_n    = 1'b0;
            busy_n  = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         mem_rw    <= RW_IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_gnt     <= 1'b0;
         d_gnt     <= 1'b0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_d    <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         mem_rw    <= rw_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         i_gnt     <= ig_n;
         d_gnt     <= dg_n;
         i_done    <= idone_n;
         d_done    <= ddone_n;
         i_rdata   <= ird_n;
         d_rdata   <= drd_n;
         busy      <= busy_n;
`ifdef MEM_ARB_RR_EN
         last_d    <= last_d_n;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n[2];
   logic        i_req[2];
   logic [31:0] i_addr[2];
   logic        i_gnt[2], i_done[2];
   logic [31:0] i_rdata[2];
   logic        d_req[2], d_we[2];
   logic [31:0] d_addr[2], d_wdata[2];
   logic        d_gnt[2], d_done[2];
   logic [31:0] d_rdata[2];
   logic [1:0]  mem_rw[2];
   logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
   logic        busy[2];

   mem_arbiter #(.MEM_LAT(2)) u0 (
      .clk(clk), .rst_n(rst_n[0]),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]), .i_done(i_done[0]), .i_rdata(i_rdata[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_gnt(d_gnt[0]), .d_done(d_done[0]), .d_rdata(d_rdata[0]),
      .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0]));

   mem_arbiter #(.MEM_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n[1]),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]), .i_done(i_done[1]), .i_rdata(i_rdata[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_gnt(d_gnt[1]), .d_done(d_done[1]), .d_rdata(d_rdata[1]),
      .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1]));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // k = cycles elapsed since the request was sampled (0 = idle);
   // 1..L access, L+1 done.
   int          k[2];
   bit          m_d[2], m_we[2], m_last_d[2], fin_i[2], fin_d[2];
   logic [31:0] m_addr[2], m_wdata[2], m_ird[2], m_drd[2];
   logic [31:0] m_log = '0;
   bit          armed = 1'b0;

   function automatic int lat(input int n);
      return (n == 0) ? 2 : 1;
   endfunction

   function automatic bit pick_d(input bit ir, input bit dr, input bit last_was_d);
`ifdef MEM_ARB_RR_EN
      return dr && (!ir || !last_was_d);
`else
      return dr;
`endif
   endfunction

   function automatic bit in_acc(input int n);
      return (k[n] >= 1) && (k[n] <= lat(n));
   endfunction

   function automatic bit in_done(input int n);
      return k[n] == lat(n) + 1;
   endfunction

   always @(posedge clk) begin
      for (int n = 0; n < 2; n++) begin
         fin_i[n] <= 1'b0;
         fin_d[n] <= 1'b0;
         if (!rst_n[n]) begin
            k[n]        <= 0;
            m_d[n]      <= 1'b0;
            m_we[n]     <= 1'b0;
            m_ird[n]    <= '0;
            m_drd[n]    <= '0;
            m_last_d[n] <= 1'b0;
         end else if (k[n] == 0) begin
            if (i_req[n] || d_req[n]) begin
               m_d[n]      <= pick_d(i_req[n], d_req[n], m_last_d[n]);
               m_we[n]     <= pick_d(i_req[n], d_req[n], m_last_d[n]) && d_we[n];
               m_addr[n]   <= pick_d(i_req[n], d_req[n], m_last_d[n]) ? d_addr[n] : i_addr[n];
               m_wdata[n]  <= d_wdata[n];
               m_last_d[n] <= pick_d(i_req[n], d_req[n], m_last_d[n]);
               k[n]        <= 1;
               if (n == 0)
                  m_log <= {m_log[23:0], pick_d(i_req[n], d_req[n], m_last_d[n]) ? 8'h44 : 8'h49};
            end
         end else if (k[n] <= lat(n)) begin
            if (k[n] == lat(n) && !m_we[n]) begin
               if (m_d[n]) m_drd[n] <= mem_rdata[n];
               else        m_ird[n] <= mem_rdata[n];
            end
            k[n] <= k[n] + 1;
         end else begin
            k[n] <= 0;
            if (m_d[n]) fin_d[n] <= 1'b1;
            else        fin_i[n] <= 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (armed) begin
         for (int n = 0; n < 2; n++) begin
            chk($sformatf("mem_rw[%0d]", n), 32'(mem_rw[n]),
                32'(in_acc(n) ? (m_we[n] ? 2 : 1) : 0));
            chk($sformatf("mem_addr[%0d]", n), mem_addr[n], in_acc(n) ? m_addr[n] : 32'h0);
            chk($sformatf("mem_wdata[%0d]", n), mem_wdata[n],
                (in_acc(n) && m_we[n]) ? m_wdata[n] : 32'h0);
            chk($sformatf("i_gnt[%0d]", n), 32'(i_gnt[n]), 32'(k[n] != 0 && !m_d[n]));
            chk($sformatf("d_gnt[%0d]", n), 32'(d_gnt[n]), 32'(k[n] != 0 && m_d[n]));
            chk($sformatf("i_done[%0d]", n), 32'(i_done[n]), 32'(in_done(n) && !m_d[n]));
            chk($sformatf("d_done[%0d]", n), 32'(d_done[n]), 32'(in_done(n) && m_d[n]));
            chk($sformatf("i_rdata[%0d]", n), i_rdata[n], m_ird[n]);
            chk($sformatf("d_rdata[%0d]", n), d_rdata[n], m_drd[n]);
            chk($sformatf("busy[%0d]", n), 32'(busy[n]), 32'(k[n] != 0));
            chk($sformatf("gnt_excl[%0d]", n), 32'(i_gnt[n] & d_gnt[n]), 32'h0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] seq, exp_seq;
   bit          pi, pd;
   bit          ip[2], dp[2];

   initial begin
      for (int n = 0; n < 2; n++) begin
         rst_n[n] = 1'b0; i_req[n] = 1'b0; i_addr[n] = '0;
         d_req[n] = 1'b0; d_we[n] = 1'b0; d_addr[n] = '0; d_wdata[n] = '0;
         mem_rdata[n] = '0; ip[n] = 1'b0; dp[n] = 1'b0;
      end
      step(); step();
      armed = 1'b1;
      chk("rst_busy", 32'(busy[0]), 32'h0);
      chk("rst_mem_rw", 32'(mem_rw[0]), 32'h0);
      chk("rst_d_rdata", d_rdata[0], 32'h0);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      // single fetch, MEM_LAT=2
      i_req[0] = 1'b1; i_addr[0] = 32'h100; mem_rdata[0] = 32'hDEADBEEF;
      step(); chk("f_rw1", 32'(mem_rw[0]), 32'h1); chk("f_addr", mem_addr[0], 32'h100);
              chk("f_gnt", 32'(i_gnt[0]), 32'h1);
      step(); chk("f_rw2", 32'(mem_rw[0]), 32'h1);
      step(); chk("f_done", 32'(i_done[0]), 32'h1); chk("f_rdata", i_rdata[0], 32'hDEADBEEF);
              chk("f_rw3", 32'(mem_rw[0]), 32'h0);
      step(); i_req[0] = 1'b0;
              chk("f_done_once", 32'(i_done[0]), 32'h0); chk("f_idle", 32'(busy[0]), 32'h0);

      // single store
      d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h200; d_wdata[0] = 32'h12345678;
      step(); chk("s_rw1", 32'(mem_rw[0]), 32'h2); chk("s_wdata", mem_wdata[0], 32'h12345678);
              chk("s_gnt", 32'(d_gnt[0]), 32'h1); chk("s_igntlow", 32'(i_gnt[0]), 32'h0);
      step(); chk("s_rw2", 32'(mem_rw[0]), 32'h2);
      step(); chk("s_done", 32'(d_done[0]), 32'h1); chk("s_rdata", d_rdata[0], 32'h0);
      step(); d_req[0] = 1'b0; d_we[0] = 1'b0;
              chk("s_done_once", 32'(d_done[0]), 32'h0);

      // both ports held for four transactions, from reset
      rst_n[0] = 1'b0; step(); rst_n[0] = 1'b1;
      i_req[0] = 1'b1; i_addr[0] = 32'h40; d_req[0] = 1'b1; d_addr[0] = 32'h80;
      seq = '0; pi = 1'b0; pd = 1'b0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (i_gnt[0] && !pi) seq = {seq[23:0], 8'h49};
         if (d_gnt[0] && !pd) seq = {seq[23:0], 8'h44};
         pi = i_gnt[0]; pd = d_gnt[0];
      end
      step(); i_req[0] = 1'b0; d_req[0] = 1'b0;
`ifdef MEM_ARB_RR_EN
      exp_seq = "DIDI";
`else
      exp_seq = "DDDD";
`endif
      chk("arb_dut", seq, exp_seq);
      chk("arb_model", m_log, exp_seq);

      // reset in the second access cycle of a load
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h300; mem_rdata[0] = 32'hCAFEF00D;
      step(); chk("r_gnt", 32'(d_gnt[0]), 32'h1);
      step(); rst_n[0] = 1'b0;
      step(); rst_n[0] = 1'b1; d_req[0] = 1'b0;
              chk("r_rw", 32'(mem_rw[0]), 32'h0); chk("r_gnt0", 32'(d_gnt[0]), 32'h0);
              chk("r_busy", 32'(busy[0]), 32'h0); chk("r_done", 32'(d_done[0]), 32'h0);
              chk("r_rdata", d_rdata[0], 32'h0);
      step(); chk("r_done2", 32'(d_done[0]), 32'h0);

      // MEM_LAT=1 back-to-back fetches
      i_req[1] = 1'b1; i_addr[1] = 32'h0; mem_rdata[1] = 32'h11111111;
      step(); chk("l1_rw", 32'(mem_rw[1]), 32'h1); chk("l1_addr", mem_addr[1], 32'h0);
              chk("l1_gnt", 32'(i_gnt[1]), 32'h1);
      step(); chk("l1_done", 32'(i_done[1]), 32'h1); chk("l1_rdata", i_rdata[1], 32'h11111111);
      step(); i_addr[1] = 32'h4; mem_rdata[1] = 32'h22222222;
              chk("l1_gap_busy", 32'(busy[1]), 32'h0); chk("l1_gap_gnt", 32'(i_gnt[1]), 32'h0);
      step(); chk("l1_rw2", 32'(mem_rw[1]), 32'h1); chk("l1_addr2", mem_addr[1], 32'h4);
      step(); chk("l1_done2", 32'(i_done[1]), 32'h1); chk("l1_rdata2", i_rdata[1], 32'h22222222);
      step(); i_req[1] = 1'b0;

      // randomized traffic on both instances
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int n = 0; n < 2; n++) begin
            mem_rdata[n] = $urandom();
            if ($urandom_range(199) == 0) begin
               rst_n[n] = 1'b0; i_req[n] = 1'b0; d_req[n] = 1'b0;
               ip[n] = 1'b0; dp[n] = 1'b0;
            end else begin
               rst_n[n] = 1'b1;
               if (fin_i[n]) ip[n] = 1'b0;
               if (fin_d[n]) dp[n] = 1'b0;
               if (!ip[n]) begin
                  if ($urandom_range(1) == 1) begin
                     ip[n] = 1'b1; i_req[n] = 1'b1; i_addr[n] = $urandom();
                  end else begin
                     i_req[n] = 1'b0;
                  end
               end
               if (!dp[n]) begin
                  if ($urandom_range(1) == 1) begin
                     dp[n] = 1'b1; d_req[n] = 1'b1; d_we[n] = 1'($urandom_range(1));
                     d_addr[n] = $urandom(); d_wdata[n] = $urandom();
                  end else begin
                     d_req[n] = 1'b0;
                  end
               end
            end
         end
      end
      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
